// File: rtl/dsp19x2_accum_result_drain.sv
// Result drain for the dual-lane 19x2 MAC: periodic snapshot of the packed result,
// per-lane signed saturation, and lane0-then-lane1 serialisation onto a valid/ready stream.
module dsp19x2_accum_result_drain #(
  parameter int unsigned DUMP_INTERVAL = 4,
  parameter int unsigned OUT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [37:0]      acc_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_lane,
  output logic             out_sat,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned LANE_W = 19;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_INTERVAL - 1);
  localparam logic signed [LANE_W-1:0] SAT_MAX = LANE_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [LANE_W-1:0] SAT_MIN = LANE_W'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_L0 = 2'd1,
    ST_SEND_L1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W:0]   r_hold0;
  logic [OUT_W:0]   r_hold1;
  logic [OUT_W:0]   w_hold0_nxt;
  logic [OUT_W:0]   w_hold1_nxt;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_lane;
  logic             r_out_sat;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;
  logic             w_snap;
  logic             w_hs;
  logic             w_drop;
  logic             w_valid_nxt;
  logic             w_lane_nxt;
  logic [OUT_W:0]   w_word_nxt;

  // Returns {sat, value} for one signed lane clipped to OUT_W bits.
  function automatic logic [OUT_W:0] f_sat(input logic [LANE_W-1:0] v);
    logic signed [LANE_W-1:0] w_s;
    w_s = $signed(v);
    if (w_s > SAT_MAX)      f_sat = {1'b1, OUT_W'(SAT_MAX)};
    else if (w_s < SAT_MIN) f_sat = {1'b1, OUT_W'(SAT_MIN)};
    else                    f_sat = {1'b0, OUT_W'(v)};
  endfunction

  assign w_snap = en && !clear && (r_cnt == CNT_LAST);
  assign w_hs   = r_out_valid && out_ready;

  // Interval counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Next state, hold-register load and drop detection
  always_comb begin
    w_state_nxt = r_state;
    w_hold0_nxt = r_hold0;
    w_hold1_nxt = r_hold1;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_snap) begin
          w_hold0_nxt = f_sat(acc_p[18:0]);
          w_hold1_nxt = f_sat(acc_p[37:19]);
          w_state_nxt = ST_SEND_L0;
        end
      end
      ST_SEND_L0: begin
        w_drop = w_snap;
        if (w_hs) w_state_nxt = ST_SEND_L1;
      end
      ST_SEND_L1: begin
        if (w_hs && w_snap) begin
          // Snapshot lands exactly as lane1 leaves: reload with no bubble.
          w_hold0_nxt = f_sat(acc_p[18:0]);
          w_hold1_nxt = f_sat(acc_p[37:19]);
          w_state_nxt = ST_SEND_L0;
        end else if (w_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_drop = w_snap;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_valid_nxt = (w_state_nxt != ST_IDLE);
    w_lane_nxt  = (w_state_nxt == ST_SEND_L1);
    case (w_state_nxt)
      ST_SEND_L0: w_word_nxt = w_hold0_nxt;
      ST_SEND_L1: w_word_nxt = w_hold1_nxt;
      default:    w_word_nxt = '0;
    endcase
  end

  // State, hold and registered stream outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_hold0     <= '0;
      r_hold1     <= '0;
      r_out_valid <= 1'b0;
      r_out_lane  <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold0     <= w_hold0_nxt;
      r_hold1     <= w_hold1_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_lane  <= w_lane_nxt;
      r_out_sat   <= w_word_nxt[OUT_W];
      r_out_data  <= w_word_nxt[OUT_W-1:0];
    end
  end

  // Drop reporting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_lane  = r_out_lane;
  assign out_sat   = r_out_sat;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/dsp19x2_accum_result_drain.md
Name: dsp19x2_accum_result_drain

Overview:
- Downstream stage of the dual-lane 19x2 multiply-accumulate block; consumes its registered 38-bit packed result P (lane1 in [37:19], lane0 in [18:0]).
- Snapshots P every DUMP_INTERVAL enabled cycles and saturates each signed 19-bit lane to OUT_W bits.
- Serialises the two lanes, lane0 first, onto a valid/ready stream toward the result sink.
- Reports snapshots lost to back-pressure.

Parameters:
- DUMP_INTERVAL, 4, enabled cycles between snapshots; legal range 2..65535.
- OUT_W, 16, output word width; signed saturation target; legal range 2..19.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  interval counter advances only when 1.
- clear  in  1  synchronous clear of interval counter, overflow and drop_cnt.
- acc_p  in  38  packed accumulator result; [18:0] lane0, [37:19] lane1, each two's complement.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts word when out_valid and out_ready are both 1.
- out_data  out  OUT_W  saturated lane value, two's complement.
- out_lane  out  1  0 = lane0 word, 1 = lane1 word.
- out_sat  out  1  1 when out_data was clipped.
- overflow  out  1  sticky; set when a snapshot is dropped.
- drop_cnt  out  8  dropped-snapshot count; saturates at 255.

Behaviour:
- Reset, asynchronous, while reset=0:
  - out_valid, out_data, out_lane, out_sat, overflow, drop_cnt are 0.
  - Interval counter is 0 and the hold registers are 0.
  - FSM is IDLE.
  - Reset asserted mid-transfer aborts the transfer immediately; no partial word is replayed after release.
- Interval counter cnt, 16 bits:
  - When en=1, cnt increments and wraps to 0 after DUMP_INTERVAL-1.
  - When en=0, cnt holds.
  - A snapshot event occurs on a cycle with en=1 and cnt==DUMP_INTERVAL-1.
- clear=1:
  - Forces cnt to 0, overflow to 0 and drop_cnt to 0.
  - Suppresses any snapshot event in the same cycle.
  - Does not affect a transfer already in progress.
- Saturation, applied per lane when the snapshot is taken:
  - If v > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1 and sat=1.
  - If v < -2^(OUT_W-1), the result is -2^(OUT_W-1) and sat=1.
  - Otherwise the result is v[OUT_W-1:0] and sat=0.
  - Saturated values and flags are stored in hold registers. Later changes on acc_p do not alter the words being sent.
- FSM states: IDLE, SEND_L0, SEND_L1.
  - IDLE: out_valid=0. A snapshot event latches both lanes into the hold registers; next state is SEND_L0.
  - SEND_L0: out_valid=1, out_lane=0, lane0 data and sat. On handshake, next state is SEND_L1; otherwise hold.
  - SEND_L1: out_valid=1, out_lane=1, lane1 data and sat. On handshake, next state is IDLE, unless a snapshot event is in the same cycle (see below).
- Latency: snapshot cycle t gives lane0 valid at t+1. With out_ready=1 throughout, lane1 is valid at t+2.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_lane and out_sat are held stable.
- Snapshot event in SEND_L1 on the same cycle as the lane1 handshake:
  - The snapshot is accepted and latched; next state is SEND_L0.
  - There is no gap and no drop.
- Snapshot event at any other time while not IDLE:
  - The snapshot is dropped.
  - overflow is set to 1 and drop_cnt increments, saturating at 255.
  - The current transfer is unaffected.
- Outputs are registered; there is no combinational path from out_ready to out_valid or out_data.

Test Plan:
- Basic transfer. Setup: DUMP_INTERVAL=4, OUT_W=16, en=1, out_ready=1, acc_p lane0=19'h00064 (100), lane1=19'h7FF9C (-100). Required response: snapshot on the 4th enabled cycle; next cycle lane0 word 16'h0064, out_lane=0, sat=0; following cycle lane1 word 16'hFF9C, out_lane=1, sat=0; then out_valid=0.
- Saturation. Stimulus: lane0=19'h1FFFF (131071), lane1=19'h40000 (-262144). Required response: words 16'h7FFF sat=1, then 16'h8000 sat=1. lane0=19'h07FFF gives 16'h7FFF sat=0.
- Back-pressure. Stimulus: out_ready=0 for 9 cycles after the first snapshot, with acc_p changing every cycle. Required response: lane0 word held constant; snapshots at +4 and +8 dropped; overflow=1, drop_cnt=2; both original words then delivered once out_ready=1.
- Back-to-back. Setup: DUMP_INTERVAL=2, out_ready=1. Required response: each snapshot coincides with the lane1 handshake; continuous alternating lane0/lane1 stream with out_valid never 0 after the first word; overflow stays 0 over 100 cycles.
- Clear vs snapshot. Stimulus: clear=1 on the cycle cnt==DUMP_INTERVAL-1, with overflow=1 and drop_cnt=3. Required response: no snapshot; cnt=0, overflow=0, drop_cnt=0; the next snapshot comes DUMP_INTERVAL enabled cycles later. Also: en=0 for 5 cycles freezes cnt.
- Reset mid-operation. Stimulus: assert reset in SEND_L1 with out_ready=0. Required response: out_valid drops to 0 asynchronously and all outputs are 0; after release, the first snapshot arrives DUMP_INTERVAL enabled cycles later.
